// File: rtl/pwm_pkg.sv
// pwm_pkg: register map, CTRL bit positions and default widths shared by the PWM bank
// and its per-channel compare slice.
package pwm_pkg;

    localparam int DEF_NUM_CH           = 8;
    localparam int DEF_CNT_W            = 16;
    localparam int DEF_PRESC_W          = 8;
    localparam int DEF_FAILSAFE_PERIODS = 50;

    // Only eight duty registers exist in the map; extra channels have no duty address.
    localparam int MAX_DUTY_REGS = 8;

    localparam logic [3:0] ADDR_PERIOD = 4'h0;
    localparam logic [3:0] ADDR_DUTY1  = 4'h1;
    localparam logic [3:0] ADDR_CTRL   = 4'h9;
    localparam logic [3:0] ADDR_PRESC  = 4'hA;

    localparam int CTRL_EN_LSB    = 0;
    localparam int CTRL_EN_W      = 8;
    localparam int CTRL_FORCE_BIT = 8;

    function automatic logic is_duty_addr(input logic [3:0] addr);
        return (addr >= ADDR_DUTY1) && (addr < ADDR_DUTY1 + 4'(MAX_DUTY_REGS));
    endfunction

endpackage

// File: rtl/pwm_compare.sv
// pwm_compare: one channel's duty shadow/active pair and its registered compare output.
module pwm_compare
    import pwm_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    input  logic             load,
    input  logic [CNT_W-1:0] cnt,
    input  logic             en,
    input  logic             period_zero,
    input  logic             block,
    output logic [CNT_W-1:0] duty_sh,
    output logic             pwm
);

    logic [CNT_W-1:0] duty_act;

    // A load on the same edge as a write takes the old shadow; the new value waits a period.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            duty_sh  <= '0;
            duty_act <= '0;
            pwm      <= 1'b0;
        end else begin
            if (wr)
                duty_sh <= wr_val;
            if (load)
                duty_act <= duty_sh;
            pwm <= en && !period_zero && !block && (cnt < duty_act);
        end
    end

endmodule

// File: rtl/pwm_channel_bank.sv
// pwm_channel_bank: shared prescaler/period counter driving NUM_CH shadowed PWM channels.
// Build with PWM_FAILSAFE_EN defined to add the write-watchdog failsafe.
module pwm_channel_bank
    import pwm_pkg::*;
#(
    parameter int NUM_CH           = DEF_NUM_CH,
    parameter int CNT_W            = DEF_CNT_W,
    parameter int PRESC_W          = DEF_PRESC_W,
    parameter int FAILSAFE_PERIODS = DEF_FAILSAFE_PERIODS
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [3:0]        rd_addr,
    output logic [15:0]       rd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick,
    output logic              failsafe
);

    // Write port: wr_en is a one-cycle strobe with no back-pressure; wr_addr/wr_data are
    // captured on the edge where wr_en is high and every write is accepted.
    logic                 running;
    logic [PRESC_W-1:0]   presc;
    logic [PRESC_W-1:0]   presc_cnt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     period_sh;
    logic [CNT_W-1:0]     period_act;
    logic [CTRL_EN_W-1:0] en_reg;
    logic                 tick;
    logic                 wrap;
    logic                 force_load;
    logic                 load;
    logic                 mapped_wr;
    logic                 fs_next;
    logic [CNT_W-1:0]     duty_sh [NUM_CH];
    logic [15:0]          rd_next;

    // The timebase stays idle after reset until the first mapped write, so no period_tick
    // is emitted before software has programmed the bank.
    assign mapped_wr  = wr_en && (wr_addr <= ADDR_PRESC);
    assign force_load = wr_en && (wr_addr == ADDR_CTRL) && wr_data[CTRL_FORCE_BIT];
    assign tick       = running && (presc_cnt >= presc);
    assign wrap       = tick && (cnt == period_act);
    assign load       = wrap || force_load;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            running     <= 1'b0;
            presc       <= '0;
            presc_cnt   <= '0;
            cnt         <= '0;
            period_sh   <= '0;
            period_act  <= '0;
            en_reg      <= '0;
            period_tick <= 1'b0;
            rd_data     <= '0;
        end else begin
            period_tick <= load;
            rd_data     <= rd_next;
            if (mapped_wr)
                running <= 1'b1;
            if (wr_en && (wr_addr == ADDR_PERIOD))
                period_sh <= CNT_W'(wr_data);
            if (wr_en && (wr_addr == ADDR_CTRL))
                en_reg <= wr_data[CTRL_EN_LSB +: CTRL_EN_W];
            if (wr_en && (wr_addr == ADDR_PRESC))
                presc <= PRESC_W'(wr_data);
            if (load)
                period_act <= period_sh;
            if (force_load) begin
                cnt       <= '0;
                presc_cnt <= '0;
            end else if (tick) begin
                presc_cnt <= '0;
                cnt       <= wrap ? '0 : cnt + CNT_W'(1);
            end else if (running) begin
                presc_cnt <= presc_cnt + PRESC_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_wr;
        logic ch_en;
        if (i < MAX_DUTY_REGS) begin : g_mapped
            assign ch_wr = wr_en && (wr_addr == ADDR_DUTY1 + 4'(i));
            assign ch_en = en_reg[i];
        end else begin : g_unmapped
            assign ch_wr = 1'b0;
            assign ch_en = 1'b0;
        end
        pwm_compare #(
            .CNT_W(CNT_W)
        ) u_cmp (
            .clk        (clk),
            .resetn     (resetn),
            .wr         (ch_wr),
            .wr_val     (CNT_W'(wr_data)),
            .load       (load),
            .cnt        (cnt),
            .en         (ch_en),
            .period_zero(period_act == '0),
            .block      (fs_next),
            .duty_sh    (duty_sh[i]),
            .pwm        (pwm_out[i])
        );
    end

    always_comb begin
        rd_next = '0;
        case (rd_addr)
            ADDR_PERIOD: rd_next = 16'(period_sh);
            ADDR_CTRL:   rd_next = 16'(en_reg);
            ADDR_PRESC:  rd_next = 16'(presc);
            default:     rd_next = '0;
        endcase
        for (int i = 0; i < NUM_CH && i < MAX_DUTY_REGS; i++) begin
            if (rd_addr == ADDR_DUTY1 + 4'(i))
                rd_next = 16'(duty_sh[i]);
        end
    end

`ifdef PWM_FAILSAFE_EN
    localparam int FS_W = $clog2(FAILSAFE_PERIODS + 1);

    logic [FS_W-1:0] fs_cnt;
    logic [FS_W-1:0] fs_cnt_next;

    // fs_next also gates the channel outputs so pwm_out drops on the same edge failsafe rises.
    always_comb begin
        fs_cnt_next = fs_cnt;
        fs_next     = failsafe;
        if (wr_en) begin
            fs_cnt_next = '0;
            fs_next     = 1'b0;
        end else if (period_tick && !failsafe) begin
            fs_cnt_next = fs_cnt + FS_W'(1);
            if (fs_cnt_next == FS_W'(FAILSAFE_PERIODS))
                fs_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fs_cnt   <= '0;
            failsafe <= 1'b0;
        end else begin
            fs_cnt   <= fs_cnt_next;
            failsafe <= fs_next;
        end
    end
`else
    assign fs_next  = 1'b0;
    assign failsafe = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_channel_bank.sv
// tb_pwm_channel_bank: register table plus scoreboarded waveform phases for pwm_channel_bank.
module tb_pwm_channel_bank;
    import pwm_pkg::*;

    localparam int NUM_CH   = 8;
    localparam int FS_LIMIT = 3;
`ifdef PWM_FAILSAFE_EN
    localparam bit FS_ON = 1'b1;
`else
    localparam bit FS_ON = 1'b0;
`endif

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_rd;
    } reg_vec_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [15:0]       wr_data;
    logic [3:0]        rd_addr;
    logic [15:0]       rd_data;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_tick;
    logic              failsafe;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [9:0]  exp_q[$];
    logic [15:0] sh_period;
    logic [15:0] sh_duty [8];
    int          presc_val;
    reg_vec_t    vecs [11];

    pwm_channel_bank #(
        .NUM_CH          (NUM_CH),
        .CNT_W           (16),
        .PRESC_W         (8),
        .FAILSAFE_PERIODS(FS_LIMIT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .failsafe   (failsafe)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
        if (a == ADDR_PERIOD)
            sh_period = d;
        else if (is_duty_addr(a))
            sh_duty[int'(a) - 1] = d;
        else if (a == ADDR_PRESC)
            presc_val = int'(d[7:0]);
    endtask

    task automatic read_check(input logic [3:0] a, input logic [15:0] exp, input string name);
        rd_addr = a;
        step();
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            step();
            check($sformatf("%s idle k=%0d", tag, k), {22'd0, failsafe, period_tick, pwm_out}, 32'd0);
        end
    endtask

    // Counter position and wrap cycles counted in samples after a FORCE_LOAD sample 0.
    function automatic int cnt_at(input int k, input int s, input int p);
        return (k / s) % (p + 1);
    endfunction

    function automatic bit tick_at(input int k, input int s, input int p);
        return (k % (s * (p + 1))) == 0;
    endfunction

    // FORCE_LOAD with the given CTRL value, then n scoreboarded samples; optional write at edge wr_k.
    task automatic run_phase(input string tag, input logic [8:0] ctrl, input int n,
                             input int wr_k, input logic [3:0] wa, input logic [15:0] wd);
        int          s;
        int          p;
        int          switch_k;
        int          fs_cnt;
        int          j;
        bit          fs;
        bit          wr_now;
        logic [15:0] d_old [8];
        logic [15:0] d_new [8];
        logic [15:0] dj;
        logic [7:0]  en;
        logic [9:0]  exp;
        logic [9:0]  got;
        s     = presc_val + 1;
        p     = int'(sh_period);
        d_old = sh_duty;
        d_new = sh_duty;
        en    = ctrl[7:0];
        if (wr_k > 0 && is_duty_addr(wa))
            d_new[int'(wa) - 1] = wd;
        switch_k = -1;
        if (wr_k > 0) begin
            switch_k = wr_k + 1;
            while (!tick_at(switch_k, s, p))
                switch_k++;
        end
        wr_en   = 1'b1;
        wr_addr = ADDR_CTRL;
        wr_data = 16'(ctrl);
        step();
        wr_en = 1'b0;
        check({tag, " tick@0"}, 32'(period_tick), 32'd1);
        check({tag, " failsafe@0"}, 32'(failsafe), 32'd0);
        fs     = 1'b0;
        fs_cnt = 0;
        for (int k = 1; k <= n; k++) begin
            j      = k - 1;
            wr_now = (k == wr_k);
            if (wr_now) begin
                fs     = 1'b0;
                fs_cnt = 0;
            end else if (FS_ON && tick_at(j, s, p) && !fs) begin
                fs_cnt++;
                if (fs_cnt == FS_LIMIT)
                    fs = 1'b1;
            end
            exp[9] = fs;
            exp[8] = tick_at(k, s, p);
            for (int c = 0; c < 8; c++) begin
                dj     = (switch_k >= 0 && j >= switch_k) ? d_new[c] : d_old[c];
                exp[c] = en[c] && (p != 0) && !fs && (cnt_at(j, s, p) < int'(dj));
            end
            exp_q.push_back(exp);
            wr_en   = wr_now;
            wr_addr = wa;
            wr_data = wd;
            step();
            wr_en = 1'b0;
            got   = {failsafe, period_tick, pwm_out};
            exp   = exp_q.pop_front();
            check($sformatf("%s k=%0d", tag, k), 32'(got), 32'(exp));
        end
        if (wr_k > 0 && is_duty_addr(wa))
            sh_duty[int'(wa) - 1] = wd;
    endtask

    initial begin
        resetn    = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
        sh_period = '0;
        presc_val = 0;
        for (int i = 0; i < 8; i++)
            sh_duty[i] = '0;

        vecs[0]  = '{4'h0, 16'd9,      16'd9};
        vecs[1]  = '{4'h1, 16'd3,      16'd3};
        vecs[2]  = '{4'h2, 16'd0,      16'd0};
        vecs[3]  = '{4'h3, 16'd20,     16'd20};
        vecs[4]  = '{4'h4, 16'd9,      16'd9};
        vecs[9]  = '{4'hB, 16'h55AA,   16'h0000};
        vecs[10] = '{4'hF, 16'hFFFF,   16'h0000};
        for (int i = 5; i <= 8; i++) begin
            logic [15:0] r;
            r       = 16'($urandom_range(0, 16'hFFFF));
            vecs[i] = '{4'(i), r, r};
        end

        // Reset state, then the idle timebase before any programming
        repeat (3) step();
        check("reset outputs", {21'd0, rd_data == 16'd0, failsafe, period_tick, pwm_out}, 32'h0000_0400);
        resetn = 1'b1;
        idle_check("post-reset", 20);
        for (int a = 0; a < 16; a++)
            read_check(4'(a), 16'd0, $sformatf("reset readback addr %0d", a));

        // Register map table: write then read back one cycle later
        for (int i = 0; i < 11; i++) begin
            write_reg(vecs[i].addr, vecs[i].data);
            read_check(vecs[i].addr, vecs[i].exp_rd, $sformatf("readback addr 0x%0h", vecs[i].addr));
        end

        // Duty cycle, boundaries and a mid-period shadow update of DUTY1
        run_phase("duty", 9'h10F, 40, 15, 4'h1, 16'd7);
        read_check(4'h1, 16'd7, "readback DUTY1 after update");

        // DUTY2 write landing exactly on the wrap edge
        run_phase("collide", 9'h10F, 40, 20, 4'h2, 16'd5);

        // Active PERIOD = 0: tick every cycle, outputs low
        write_reg(ADDR_PERIOD, 16'd0);
        run_phase("period0", 9'h10F, 12, -1, 4'h0, 16'd0);

        // Prescaler 3 with PERIOD 4, then FORCE_LOAD mid-period with all channels enabled
        write_reg(ADDR_PRESC, 16'd3);
        write_reg(ADDR_PERIOD, 16'd4);
        run_phase("presc", 9'h10F, 45, -1, 4'h0, 16'd0);
        run_phase("force", 9'h1FF, 30, 7, 4'h3, 16'd2);

        // Write-free periods, then one ignored-address write
        write_reg(ADDR_PRESC, 16'd0);
        write_reg(ADDR_PERIOD, 16'd9);
        run_phase("failsafe", 9'h10F, 40, 32, 4'hB, 16'd0);

        // One-cycle reset in the middle of operation
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("mid-op reset outputs", {21'd0, rd_data == 16'd0, failsafe, period_tick, pwm_out}, 32'h0000_0400);
        sh_period = '0;
        presc_val = 0;
        for (int i = 0; i < 8; i++)
            sh_duty[i] = '0;
        idle_check("after mid-op reset", 25);
        for (int a = 0; a < 16; a++)
            read_check(4'(a), 16'd0, $sformatf("post-reset readback addr %0d", a));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pwm_channel_bank.md
PWM_CHANNEL_BANK -- requirements
Module: pwm_channel_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, the number of PWM channels.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the counter, period and duty values.
REQ-003 SHALL have parameter PRESC_W, default 8, the width of the prescaler register.
REQ-004 SHALL have parameter FAILSAFE_PERIODS, default 50, the number of write-free periods before failsafe trips.
REQ-005 SHALL have port clk, input, 1 bit, the single system clock (on-chip oscillator); one clock, no other clock domains.
REQ-006 SHALL have port resetn, input, 1 bit, a synchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1 bit, a single-cycle register write strobe from the I2C slave register stage.
REQ-008 SHALL have port wr_addr, input, 4 bits, the register address.
REQ-009 SHALL have port wr_data, input, 16 bits, the write data.
REQ-010 SHALL have port rd_addr, input, 4 bits, the readback address.
REQ-011 SHALL have port rd_data, output, 16 bits, the readback data, registered.
REQ-012 SHALL have port pwm_out, output, NUM_CH bits; bit i drives channel i+1.
REQ-013 SHALL have port period_tick, output, 1 bit, a one-cycle pulse at each period wrap.
REQ-014 SHALL have port failsafe, output, 1 bit, high while failsafe is active.

Function
REQ-015 SHALL use this register map: 0x0 PERIOD; 0x1..0x8 DUTY ch1..ch8; 0x9 CTRL; 0xA PRESC.
- CTRL[7:0] holds the per-channel enables.
- CTRL[8] is write-only FORCE_LOAD.
- Addresses 0xB..0xF are ignored on write and read 0.
REQ-016 SHALL hold PERIOD and DUTY in shadow registers. A write updates the shadow on the cycle after the wr_en cycle.
REQ-017 SHALL apply CTRL enables and PRESC on the cycle after the write; these registers are not shadowed.
REQ-018 SHALL generate a prescaler tick every PRESC+1 clk cycles. PRESC=0 means a tick every cycle.
REQ-019 SHALL advance the counter by 1 on each tick.
- On a tick with counter == active PERIOD: counter goes to 0, all shadows copy to the active registers, and period_tick pulses for exactly 1 cycle.
REQ-020 SHALL give shadow loading precedence over a same-cycle write. When a write coincides with a load, the load uses the pre-write shadow value and the new value takes effect at the following wrap.
REQ-021 SHALL, on a write of FORCE_LOAD=1, load the shadows, zero the counter and prescaler, and pulse period_tick, all on the next cycle.
REQ-022 SHALL drive each pwm_out bit registered as: pwm_out[i] = en[i] AND (counter < duty_act[i]). This gives 1-cycle latency from the counter.
REQ-023 SHALL treat the duty boundaries as follows:
- duty_act = 0 gives a constant low.
- duty_act > period_act gives a constant high.
- duty_act = period_act gives high for period_act of every period_act+1 counts.
REQ-024 SHALL, when active PERIOD = 0, hold the counter at 0, force all pwm_out low, and pulse period_tick on every tick.
REQ-025 SHALL return shadow values on rd_data for PERIOD and DUTY, with one cycle of latency.

Reset
REQ-026 SHALL, on resetn=0 sampled at a clk edge, set the following:
- all shadow and active registers to 0;
- CTRL to 0 and PRESC to 0;
- counter and prescaler to 0;
- pwm_out, period_tick and rd_data to 0;
- failsafe to 0 and the failsafe counter to 0.
REQ-027 SHALL, when reset is applied mid-period, drive all outputs low on the first cycle after the sampling edge.

Configuration
REQ-028 SHALL implement the failsafe when macro PWM_FAILSAFE_EN is defined.
- Each period_tick without any wr_en since the last write increments the failsafe counter.
- When the counter reaches FAILSAFE_PERIODS, failsafe goes to 1 and pwm_out is forced to 0.
- Any wr_en clears the counter and failsafe on the next cycle.
- No register values are altered by the failsafe.
REQ-029 SHALL, when PWM_FAILSAFE_EN is undefined, contain no failsafe counter and tie failsafe to constant 0.

Structure
REQ-030 SHALL place the register address constants, the CTRL bit positions and the default widths in shared package pwm_pkg.
REQ-031 SHALL instantiate one sub-module, pwm_compare, NUM_CH times. Each instance holds the shadow and active duty for one channel and produces the registered output bit.

Verification
REQ-032 SHALL cover duty cycle: PRESC=0, PERIOD=9, DUTY1=3, EN=0x01 -> pwm_out[0] high 3 of every 10 cycles, period_tick every 10 cycles.
REQ-033 SHALL cover shadow update: write DUTY1=7 mid-period -> the old duty persists until the next period_tick, then 7/10 high; read DUTY1 -> 7.
REQ-034 SHALL cover boundaries and write collision: DUTY2=0 -> constant low; DUTY3=20 with PERIOD=9 -> constant high; a write on the exact load cycle takes effect one period later.
REQ-035 SHALL cover prescaler and FORCE_LOAD: PRESC=3, PERIOD=4 -> period_tick every 20 cycles; CTRL=0x1FF mid-period -> the counter restarts the next cycle.
REQ-036 SHALL cover failsafe: with PWM_FAILSAFE_EN and FAILSAFE_PERIODS=3, no writes -> failsafe=1 and pwm_out=0 after the 3rd period_tick; one write -> outputs resume the next cycle.
REQ-037 SHALL cover reset mid-operation: resetn low for 1 cycle mid-period -> all outputs 0 and all registers 0, with no period_tick until reprogrammed.
